tick_timer: RTL and testbench



---
 rtl/tick_timer.sv | 118 +++++++++++
 tb/tb_tick_timer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tick_timer.sv
// Programmable down-timer driven by prescaler overflow ticks.
// Counts a loaded period and pulses expired once per expiry, one-shot or periodic.
module tick_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_period,
  input  logic             load_mode,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             expired,
  output logic [WIDTH-1:0] count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             expired_q, expired_d;
  logic             load_fire_s;

  assign load_fire_s = load_valid & (state_q != S_RUN);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      period_q  <= CNT_ZERO;
      mode_q    <= 1'b0;
      count_q   <= CNT_ZERO;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      mode_q    <= mode_d;
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  // Next-state logic; a load outranks start/stop, and in RUN stop outranks tick
  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    mode_d    = mode_q;
    count_d   = count_q;
    expired_d = 1'b0;
    if (load_fire_s) begin
      period_d = load_period;
      count_d  = load_period;
      mode_d   = load_mode;
      if (load_period != CNT_ZERO) begin
        state_d = S_ARMED;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_ARMED: begin
          if (stop) begin
            count_d = period_q;
          end else if (start) begin
            state_d = S_RUN;
          end else begin
            state_d = S_ARMED;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_d = S_ARMED;
            count_d = period_q;
          end else if (tick) begin
            if (count_q > CNT_ONE) begin
              count_d = count_q - CNT_ONE;
            end else if (mode_q) begin
              // Periodic reload: the expiring tick also starts the next period
              count_d   = period_q;
              expired_d = 1'b1;
            end else begin
              count_d   = CNT_ZERO;
              state_d   = S_IDLE;
              expired_d = 1'b1;
            end
          end else begin
            count_d = count_q;
          end
        end
        default: begin
          state_d = S_IDLE;
          count_d = CNT_ZERO;
        end
      endcase
    end
  end

  assign busy       = (state_q == S_RUN);
  assign load_ready = (state_q != S_RUN);
  assign expired    = expired_q;
  assign count      = count_q;

endmodule

// File: tb/tb_tick_timer.sv
// Scoreboard bench for tick_timer: stimulus pushes expected snapshots and
// expiry events; a negedge monitor pops and compares them.
module tb_tick_timer;

  logic        clk;
  logic        rst;
  logic        tick;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_period;
  logic        load_mode;
  logic        start;
  logic        stop;
  logic        busy;
  logic        expired;
  logic [15:0] count;

  typedef struct {
    string       name;
    logic        busy;
    logic        ready;
    logic [15:0] cnt;
    logic        exp;
  } snap_t;

  typedef struct {
    logic [15:0] cnt;
    logic        busy;
  } expiry_t;

  snap_t   snap_q[$];
  expiry_t exp_q[$];
  int      checks;
  int      errors;

  tick_timer #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_period(load_period),
    .load_mode  (load_mode),
    .start      (start),
    .stop       (stop),
    .busy       (busy),
    .expired    (expired),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap(input string name, input logic b, input logic r,
                      input logic [15:0] c, input logic e);
    snap_t s;
    s.name = name; s.busy = b; s.ready = r; s.cnt = c; s.exp = e;
    snap_q.push_back(s);
  endtask

  task automatic expect_expiry(input logic [15:0] c, input logic b);
    expiry_t x;
    x.cnt = c; x.busy = b;
    exp_q.push_back(x);
  endtask

  task automatic do_load(input logic [15:0] p, input logic m);
    load_valid = 1'b1; load_period = p; load_mode = m;
    step(1);
    load_valid = 1'b0;
  endtask

  // Monitor: compare queued snapshots and every expired pulse against expectations
  always @(negedge clk) begin
    while (snap_q.size() > 0) begin
      snap_t s;
      s = snap_q.pop_front();
      checks++;
      if (busy !== s.busy || load_ready !== s.ready || count !== s.cnt || expired !== s.exp) begin
        errors++;
        $display("FAIL %s: got busy=%b ready=%b count=%h expired=%b, want busy=%b ready=%b count=%h expired=%b",
                 s.name, busy, load_ready, count, expired, s.busy, s.ready, s.cnt, s.exp);
      end
    end
    if (expired === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_expired: got expired=1 count=%h, want no expiry", count);
      end else begin
        expiry_t x;
        x = exp_q.pop_front();
        if (count !== x.cnt || busy !== x.busy) begin
          errors++;
          $display("FAIL expiry: got count=%h busy=%b, want count=%h busy=%b", count, busy, x.cnt, x.busy);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; tick = 1'b0; load_valid = 1'b0; load_period = 16'h0000;
    load_mode = 1'b0; start = 1'b0; stop = 1'b0;
    step(2);
    rst = 1'b1;
    snap("reset", 1'b0, 1'b1, 16'h0000, 1'b0);
    step(1);
    tick = 1'b1; start = 1'b1; stop = 1'b1;
    step(2);
    tick = 1'b0; start = 1'b0; stop = 1'b0;
    snap("idle_ignores", 1'b0, 1'b1, 16'h0000, 1'b0);
    step(1);

    // One-shot, period 3
    do_load(16'd3, 1'b0);
    snap("os_armed", 1'b0, 1'b1, 16'd3, 1'b0);
    start = 1'b1; step(1); start = 1'b0;
    snap("os_run", 1'b1, 1'b0, 16'd3, 1'b0);
    tick = 1'b1; step(1); tick = 1'b0;
    snap("os_cnt2", 1'b1, 1'b0, 16'd2, 1'b0);
    step(1);
    tick = 1'b1; step(1); tick = 1'b0;
    snap("os_cnt1", 1'b1, 1'b0, 16'd1, 1'b0);
    step(1);
    expect_expiry(16'd0, 1'b0);
    tick = 1'b1; step(1); tick = 1'b0;
    snap("os_done", 1'b0, 1'b1, 16'd0, 1'b1);
    step(1);
    snap("os_pulse_end", 1'b0, 1'b1, 16'd0, 1'b0);

    // Periodic, period 1, tick held high
    do_load(16'd1, 1'b1);
    start = 1'b1; step(1); start = 1'b0;
    tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_expiry(16'd1, 1'b1);
      step(1);
      snap("per_exp", 1'b1, 1'b0, 16'd1, 1'b1);
    end
    tick = 1'b0;
    step(1);
    snap("per_quiet", 1'b1, 1'b0, 16'd1, 1'b0);
    stop = 1'b1; step(1); stop = 1'b0;
    snap("per_stopped", 1'b0, 1'b1, 16'd1, 1'b0);

    // Stop beats tick at count 1
    do_load(16'd2, 1'b0);
    start = 1'b1; step(1); start = 1'b0;
    tick = 1'b1; step(1); tick = 1'b0;
    snap("sp_cnt1", 1'b1, 1'b0, 16'd1, 1'b0);
    stop = 1'b1; tick = 1'b1; step(1); stop = 1'b0; tick = 1'b0;
    snap("sp_armed", 1'b0, 1'b1, 16'd2, 1'b0);
    step(1);
    start = 1'b1; step(1); start = 1'b0;
    snap("sp_resume", 1'b1, 1'b0, 16'd2, 1'b0);
    tick = 1'b1; step(1);
    expect_expiry(16'd0, 1'b0);
    step(1); tick = 1'b0;
    snap("sp_done", 1'b0, 1'b1, 16'd0, 1'b1);

    // Load ignored in RUN
    do_load(16'd5, 1'b1);
    start = 1'b1; step(1); start = 1'b0;
    load_valid = 1'b1; load_period = 16'd9; load_mode = 1'b0;
    snap("ld_run_notready", 1'b1, 1'b0, 16'd5, 1'b0);
    step(1); load_valid = 1'b0;
    snap("ld_run_ignored", 1'b1, 1'b0, 16'd5, 1'b0);
    stop = 1'b1; step(1); stop = 1'b0;
    snap("ld_period_kept", 1'b0, 1'b1, 16'd5, 1'b0);

    // Load outranks start in ARMED
    load_valid = 1'b1; load_period = 16'd4; load_mode = 1'b0; start = 1'b1;
    step(1); load_valid = 1'b0; start = 1'b0;
    snap("ld_over_start", 1'b0, 1'b1, 16'd4, 1'b0);

    // Period 0 goes IDLE and start is ignored
    do_load(16'd0, 1'b0);
    snap("ld_zero", 1'b0, 1'b1, 16'd0, 1'b0);
    start = 1'b1; tick = 1'b1; step(1); start = 1'b0; tick = 1'b0;
    snap("zero_start_ign", 1'b0, 1'b1, 16'd0, 1'b0);

    // Max period, then async reset mid-run
    do_load(16'hFFFF, 1'b1);
    snap("max_armed", 1'b0, 1'b1, 16'hFFFF, 1'b0);
    start = 1'b1; step(1); start = 1'b0;
    tick = 1'b1; step(2); tick = 1'b0;
    snap("max_run", 1'b1, 1'b0, 16'hFFFD, 1'b0);
    step(1);
    #2;
    rst = 1'b0;
    snap("async_reset", 1'b0, 1'b1, 16'h0000, 1'b0);
    step(1);
    rst = 1'b1;
    step(1);
    snap("after_reset", 1'b0, 1'b1, 16'h0000, 1'b0);
    step(2);

    checks++;
    if (exp_q.size() != 0 || snap_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: got %0d expiries and %0d snapshots pending, want 0 and 0",
               exp_q.size(), snap_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
